regfile_mp: RTL and testbench
=============================

# regfile_mp

Multi-ported integer register file with same-cycle write bypass and a per-register busy scoreboard. It is the next generation of the single-write, two-read core register file: read-port and write-port counts are parametrised, written data forwards combinationally to readers, and pending-write reservations let the issue stage detect RAW hazards. It sits between decode/issue (read and reserve) and writeback (write) in the LemonPC pipeline.

## Interface
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 64, register width.
- NUM_RD, 3, number of read ports.
- NUM_WR, 2, number of write ports.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset; one clock; synchronous, active-low.
- rd_addr  in  NUM_RD*ADDR_WIDTH  packed read indices, port i at slice i.
- rd_data  out  NUM_RD*DATA_WIDTH  packed read data, combinational.
- rd_busy  out  NUM_RD  scoreboard busy bit of each read index, combinational.
- wr_en  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR*ADDR_WIDTH  write indices.
- wr_data  in  NUM_WR*DATA_WIDTH  write data.
- rsv_en  in  1  reserve rsv_addr as pending-write (set busy).
- rsv_addr  in  ADDR_WIDTH  index to reserve.
- flush  in  1  clear all busy bits (pipeline squash); register contents untouched.

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH array plus 2**ADDR_WIDTH busy bits.
- Register 0: always reads 0, never busy; writes and reservations to index 0 ignored.
- Write: on rising edge, each port j with wr_en[j]=1 and wr_addr[j]!=0 stores wr_data[j] and clears busy[wr_addr[j]].
- Write conflict: multiple enabled ports on same index -> highest-numbered port wins, for storage and bypass.
- Read: rd_data[i] = winning same-cycle write data if any enabled port targets rd_addr[i] (write-first bypass); else stored value; 0 for index 0.
- rd_busy[i]: busy[rd_addr[i]] after applying same-cycle writes (a write to that index this cycle forces rd_busy=0), unless rsv_en targets it this cycle — reservation not visible until next cycle.
- Reserve: on edge, rsv_en=1 and rsv_addr!=0 sets busy[rsv_addr].
- Reserve + write same index same edge: busy ends 1 (new producer supersedes retiring one); data still written.
- flush: on edge, all busy bits -> 0; overrides reserve in same cycle; same-cycle writes still commit.
- Reset (rst_n=0 at edge): all registers 0, all busy 0; writes, reserves, flush ignored. While rst_n=0, bypass is disabled and rd_busy reads 0.

## Timing
- Read and rd_busy: zero latency, combinational from addresses, wr_*, and state.
- Write/reserve/flush: visible in state one cycle later (bypass covers data in the write cycle).
- Reset values: rd_data = 0 for all ports and rd_busy = 0 from the cycle after the first reset edge; outputs are stored-array-derived before that.
- Reset asserted mid-operation: the edge with rst_n=0 discards all pending writes and reservations in that cycle.
- No handshakes; every enabled request is accepted every cycle.

## Structure
- Shared package regfile_pkg: default ADDR_WIDTH/DATA_WIDTH constants, ZERO_REG index localparam.
- One sub-module: regfile_wr_arb — per-index priority select across NUM_WR ports (hit flag + winning data), instantiated once per read port for bypass and reused for the storage write decode.
- Scoreboard logic kept inline; no FSM beyond per-register busy bits.

## Test plan
- Reset: hold rst_n=0 with wr_en=2'b11 to x5 data 0xAA -> after release, x5 reads 0, all rd_busy 0.
- Bypass: port0 writes x7=0x1234 while rd_addr[0]=7 -> rd_data[0]=0x1234 same cycle; stored value 0x1234 next cycle.
- Conflict: port0 x3=0x11, port1 x3=0x22 same cycle -> bypass and stored value 0x22.
- x0: write x0=0xFFFF and rsv x0 -> rd_data=0, rd_busy=0.
- Scoreboard: rsv x9 cycle N -> rd_busy=0 in N, 1 in N+1; write x9 in N+3 -> rd_busy=0 in N+3; reserve+write x9 same edge -> busy 1 after.
- Flush: reserve x4, x6, then flush with rsv_en on x8 -> all busy 0 next cycle, register contents unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants for the multi-ported register file
package regfile_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_NUM_RD     = 3;
    localparam int DEF_NUM_WR     = 2;

    // Hard-wired zero register index
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write/reserve bus of the multi-ported register file
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int NUM_WR     = DEF_NUM_WR
) ();

    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_busy;
    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
    logic                         rsv_en;
    logic [ADDR_WIDTH-1:0]        rsv_addr;
    logic                         flush;

    modport master (
        output rd_addr,
        input  rd_data,
        input  rd_busy,
        output wr_en,
        output wr_addr,
        output wr_data,
        output rsv_en,
        output rsv_addr,
        output flush
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        output rd_busy,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rsv_en,
        input  rsv_addr,
        input  flush
    );

endinterface

// File: rtl/regfile_wr_arb.sv
// rtl/regfile_wr_arb.sv - priority select of write ports targeting one index
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_WR     = DEF_NUM_WR
) (
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0]        addr,
    output logic                         hit,
    output logic [DATA_WIDTH-1:0]        data
);

    // Scan ports in ascending order so the highest-numbered matching port wins
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == addr)) begin
                hit  = 1'b1;
                data = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-ported register file with write bypass and busy scoreboard
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int NUM_WR     = DEF_NUM_WR
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);

    localparam int                    DEPTH    = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;

    logic [DEPTH-1:0]      wr_hit;
    logic [DATA_WIDTH-1:0] wr_win [DEPTH];

    // Per-index write decode: which port (if any) lands on each register this cycle
    for (genvar k = 0; k < DEPTH; k++) begin : g_wr_dec
        regfile_wr_arb #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_WR     (NUM_WR)
        ) u_arb (
            .wr_en   (bus.wr_en),
            .wr_addr (bus.wr_addr),
            .wr_data (bus.wr_data),
            .addr    (ADDR_WIDTH'(k)),
            .hit     (wr_hit[k]),
            .data    (wr_win[k])
        );
    end

    // Read ports: write-first bypass, zero register forced, bypass off in reset
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic                  hit;
        logic [DATA_WIDTH-1:0] win;

        assign addr = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

        regfile_wr_arb #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_WR     (NUM_WR)
        ) u_arb (
            .wr_en   (bus.wr_en),
            .wr_addr (bus.wr_addr),
            .wr_data (bus.wr_data),
            .addr    (addr),
            .hit     (hit),
            .data    (win)
        );

        assign bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
            (addr == ZERO_IDX) ? '0 :
            (rst_n && hit)     ? win : mem_q[addr];

        // A retiring write hides the old busy bit; a same-cycle reserve is not yet visible
        assign bus.rd_busy[i] = rst_n && (addr != ZERO_IDX) && !hit && busy_q[addr];
    end

    // Next storage contents: winning write data per index, register 0 pinned to zero
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            mem_d[k] = mem_q[k];
            if (k == ZERO_REG) begin
                mem_d[k] = '0;
            end else if (wr_hit[k]) begin
                mem_d[k] = wr_win[k];
            end
        end
    end

    // Next busy bits: writes retire, reserve sets afterwards so it supersedes, flush clears all
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (wr_hit[k]) begin
                busy_d[k] = 1'b0;
            end
        end
        if (bus.rsv_en && (bus.rsv_addr != ZERO_IDX)) begin
            busy_d[bus.rsv_addr] = 1'b1;
        end
        if (bus.flush) begin
            busy_d = '0;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    // State registers with synchronous active-low reset discarding same-cycle requests
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp
module tb_regfile_mp;

    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NR = 3;
    localparam int NW = 2;
    localparam int DEPTH = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    regfile_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

    regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural model: register values, pending-write flags, valid after first reset
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];
    bit            m_init;

    function automatic int rd_a(int i);
        logic [AW-1:0] a;
        a = bus.rd_addr[i*AW +: AW];
        return int'(a);
    endfunction

    // Last enabled port writing index a this cycle, or -1
    function automatic int winner(int a);
        int w;
        logic [AW-1:0] wa;
        w = -1;
        for (int j = 0; j < NW; j++) begin
            wa = bus.wr_addr[j*AW +: AW];
            if (bus.wr_en[j] && int'(wa) == a) w = j;
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] exp_data(int i);
        int a;
        int w;
        a = rd_a(i);
        if (a == 0) return '0;
        w = winner(a);
        if (rst_n && w >= 0) return bus.wr_data[w*DW +: DW];
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(int i);
        int a;
        a = rd_a(i);
        if (!rst_n || a == 0 || winner(a) >= 0) return 1'b0;
        return m_busy[a];
    endfunction

    // Model commit on each rising edge
    always @(posedge clk) begin
        int a;
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_mem[k]  = '0;
                m_busy[k] = 1'b0;
            end
            m_init = 1'b1;
        end else begin
            for (int j = 0; j < NW; j++) begin
                a = int'(bus.wr_addr[j*AW +: AW]);
                if (bus.wr_en[j] && a != 0) begin
                    m_mem[a]  = bus.wr_data[j*DW +: DW];
                    m_busy[a] = 1'b0;
                end
            end
            a = int'(bus.rsv_addr);
            if (bus.rsv_en && a != 0) m_busy[a] = 1'b1;
            if (bus.flush) begin
                for (int k = 0; k < DEPTH; k++) m_busy[k] = 1'b0;
            end
        end
    end

    // Compare every read port against the model away from the active edge
    always @(negedge clk) begin
        if (m_init) begin
            for (int i = 0; i < NR; i++) begin
                checks++;
                if (bus.rd_data[i*DW +: DW] !== exp_data(i)) begin
                    failures++;
                    $display("FAIL model_rd_data port=%0d addr=%0d got=%h exp=%h t=%0t",
                             i, rd_a(i), bus.rd_data[i*DW +: DW], exp_data(i), $time);
                end
                checks++;
                if (bus.rd_busy[i] !== exp_busy(i)) begin
                    failures++;
                    $display("FAIL model_rd_busy port=%0d addr=%0d got=%b exp=%b t=%0t",
                             i, rd_a(i), bus.rd_busy[i], exp_busy(i), $time);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en  = '0;
        bus.rsv_en = 1'b0;
        bus.flush  = 1'b0;
    endtask

    task automatic set_rd(input int i, input int a);
        bus.rd_addr[i*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int j, input int a, input logic [DW-1:0] d);
        bus.wr_en[j]             = 1'b1;
        bus.wr_addr[j*AW +: AW]  = AW'(a);
        bus.wr_data[j*DW +: DW]  = d;
    endtask

    task automatic set_rsv(input int a);
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = AW'(a);
    endtask

    function automatic logic [DW-1:0] rdd(int i);
        return bus.rd_data[i*DW +: DW];
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        m_init   = 1'b0;
        rst_n    = 1'b0;
        bus.rd_addr  = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rsv_addr = '0;
        idle();

        // Reset held while both ports write x5
        set_rd(0, 5); set_rd(1, 5); set_rd(2, 0);
        set_wr(0, 5, 64'hAA); set_wr(1, 5, 64'hAA);
        set_rsv(5);
        cyc();
        #3;
        chk("reset_bypass_off", rdd(0), 64'h0);
        chk("reset_busy_off", 64'(bus.rd_busy), 64'h0);
        cyc();
        rst_n = 1'b1;
        idle();
        #3;
        chk("reset_x5_zero", rdd(1), 64'h0);
        chk("reset_busy_zero", 64'(bus.rd_busy), 64'h0);

        // Same-cycle bypass then stored value
        cyc();
        set_rd(0, 7);
        set_wr(0, 7, 64'h1234);
        #3;
        chk("bypass_same_cycle", rdd(0), 64'h1234);
        cyc();
        idle();
        #3;
        chk("bypass_stored", rdd(0), 64'h1234);

        // Two ports on x3: higher port wins
        cyc();
        set_rd(1, 3);
        set_wr(0, 3, 64'h11); set_wr(1, 3, 64'h22);
        #3;
        chk("conflict_bypass", rdd(1), 64'h22);
        cyc();
        idle();
        #3;
        chk("conflict_stored", rdd(1), 64'h22);

        // x0 ignores write and reserve
        cyc();
        set_rd(2, 0);
        set_wr(0, 0, 64'hFFFF);
        set_rsv(0);
        #3;
        chk("x0_bypass", rdd(2), 64'h0);
        cyc();
        idle();
        #3;
        chk("x0_stored", rdd(2), 64'h0);
        chk("x0_busy", 64'(bus.rd_busy[2]), 64'h0);

        // Scoreboard on x9
        cyc();
        set_rd(0, 9);
        set_rsv(9);
        #3;
        chk("rsv_invisible", 64'(bus.rd_busy[0]), 64'h0);
        cyc();
        idle();
        #3;
        chk("rsv_visible", 64'(bus.rd_busy[0]), 64'h1);
        cyc();
        cyc();
        set_wr(1, 9, 64'h99);
        #3;
        chk("write_clears_busy", 64'(bus.rd_busy[0]), 64'h0);
        chk("write_data_x9", rdd(0), 64'h99);
        cyc();
        idle();
        #3;
        chk("busy_cleared", 64'(bus.rd_busy[0]), 64'h0);
        cyc();
        set_rsv(9);
        set_wr(0, 9, 64'h55);
        cyc();
        idle();
        #3;
        chk("rsv_write_busy", 64'(bus.rd_busy[0]), 64'h1);
        chk("rsv_write_data", rdd(0), 64'h55);

        // Flush overrides a same-cycle reserve, contents untouched
        cyc();
        set_rsv(4);
        set_wr(0, 4, 64'hC4);
        cyc();
        idle();
        set_rsv(6);
        cyc();
        idle();
        set_rd(0, 4); set_rd(1, 6); set_rd(2, 8);
        set_rsv(8);
        bus.flush = 1'b1;
        #3;
        chk("pre_flush_busy", 64'(bus.rd_busy), 64'h3);
        cyc();
        idle();
        #3;
        chk("flush_busy", 64'(bus.rd_busy), 64'h0);
        chk("flush_data", rdd(0), 64'hC4);
        set_rd(2, 9);
        #1;
        chk("flush_x9", 64'(bus.rd_busy[2]), 64'h0);

        // Mixed traffic checked by the model alone
        for (int n = 0; n < 40; n++) begin
            cyc();
            idle();
            for (int i = 0; i < NR; i++) set_rd(i, $urandom_range(0, 7));
            for (int j = 0; j < NW; j++) begin
                if ($urandom_range(0, 1) == 1) set_wr(j, $urandom_range(0, 7), {$urandom, $urandom});
            end
            if ($urandom_range(0, 1) == 1) set_rsv($urandom_range(0, 7));
            bus.flush = ($urandom_range(0, 7) == 0);
        end

        // Reset mid-operation discards a pending write
        cyc();
        idle();
        set_wr(0, 10, 64'hAB);
        set_rsv(10);
        set_rd(0, 10); set_rd(1, 7);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        idle();
        #3;
        chk("midreset_x10", rdd(0), 64'h0);
        chk("midreset_x7", rdd(1), 64'h0);
        chk("midreset_busy", 64'(bus.rd_busy), 64'h0);
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
